mdu_seq: RTL
============

Name: mdu_seq

Overview:
Iterative multiply/divide unit for the CPU datapath. It takes the same 32-bit operand pair the ALU uses and produces a 64-bit HI/LO result over a fixed number of cycles. The control path drives it with a start/busy/done handshake. Its HI/LO results feed the mfhi/mflo path.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
a  input  WIDTH  operand 1 (multiplicand / dividend)
b  input  WIDTH  operand 2 (multiplier / divisor)
op  input  2  0=MULTU, 1=MULT, 2=DIVU, 3=DIV
start  input  1  request; sampled on rising clk when busy=0
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
hi  output  WIDTH  MULT*: product[63:32]; DIV*: remainder
lo  output  WIDTH  MULT*: product[31:0]; DIV*: quotient

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. While rst=1: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers cleared.
- States: IDLE, CALC, SIGN, DONE.
- IDLE/DONE with start=1 at an edge:
  - latch op, magnitudes |a| and |b|, and sign flags; signed interpretation applies only for op=1,3
  - clear accumulator and counter; go to CALC
- IDLE/DONE with start=0: DONE -> IDLE; IDLE stays.
- CALC: one iteration per cycle for WIDTH cycles, counter 0..WIDTH-1; on the last iteration go to SIGN.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring division; shift remainder/quotient left, trial-subtract divisor, set quotient bit when the result is non-negative.
- SIGN, one cycle:
  - MULT: negate the 64-bit product if sign(a)^sign(b).
  - DIV: negate quotient if sign(a)^sign(b); negate remainder if sign(a).
  - Write hi/lo; go to DONE.
- DONE, one cycle: done=1.
- Timing: busy=1 exactly in CALC and SIGN (WIDTH+1 = 33 cycles). done rises WIDTH+2 = 34 edges after the accepting edge. hi/lo are valid when done=1 and held until the next operation's SIGN cycle.
- start while busy=1 is ignored, not queued. Operands and op may change freely after the accepting edge.
- start in DONE is accepted: done=1 in that cycle, busy=1 next cycle.
- Divide by zero (b=0, DIVU or DIV): no trap, normal latency. Result is lo=all ones, hi=a, taken unmodified with no sign fix; this is the natural restoring result, forced in SIGN.
- DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, by wrap-around of magnitude negation.
- MULT of 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- rst during CALC/SIGN: abort immediately; no done pulse; hi/lo=0.
- All arithmetic is modulo 2^WIDTH per output word; no exceptions or flags.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start pulse -> busy=1 for 33 cycles, done pulse on edge 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done after normal latency, lo=0xFFFFFFFF, hi=0x1234.
- Start MULTU 3*4, then pulse start with DIVU 9/3 on cycle 10 while busy -> second request ignored; result hi=0, lo=12. Start in the DONE cycle -> accepted, busy next cycle.
- Start MULTU 2*2, assert rst on cycle 15 for 2 cycles -> busy=0, done never pulses, hi=lo=0. A fresh MULTU 6*7 afterwards -> lo=42.

Source files
------------

// File: rtl/mdu_if.sv
// Start/busy/done handshake and HI/LO result bus between the control path and mdu_seq.
// The control path is the master; the multiply/divide unit is the slave.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output a, b, op, start, input  busy, done, hi, lo);
    modport slave  (input  a, b, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide on operand
// magnitudes over WIDTH cycles, then a single sign-fix cycle that writes HI/LO.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b, sh;
    logic               neg_a, neg_b, op_div;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               accept, last_iter;
    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH-1:0]   rem, quo, mult_add;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] step_nxt, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Signed interpretation only for MULT (op=1) and DIV (op=3).
    assign in_neg_a = bus.op[0] & bus.a[WIDTH-1];
    assign in_neg_b = bus.op[0] & bus.b[WIDTH-1];
    assign in_mag_a = in_neg_a ? -bus.a : bus.a;
    assign in_mag_b = in_neg_b ? -bus.b : bus.b;

    assign rem = acc[2*WIDTH-1:WIDTH];
    assign quo = acc[WIDTH-1:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mult_add = '0;
        rem_sh   = {rem, sh[WIDTH-1]};
        trial    = {1'b0, rem_sh} - {2'b00, mag_b};
        step_nxt = acc;
        if (op_div) begin
            // A dropped rem MSB means rem_sh >= 2^WIDTH > divisor, so that path never restores.
            if (trial[WIDTH+1])
                step_nxt = {rem_sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
            else
                step_nxt = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            if (sh[WIDTH-1])
                mult_add = mag_a;
            step_nxt = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, mult_add};
        end
    end

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
        rem_fix  = neg_a ? -rem : rem;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = SIGN;
            SIGN:    state_nxt = DONE;
            DONE:    state_nxt = bus.start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC) || (state == SIGN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sh     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_div <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_div <= bus.op[1];
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        sh     <= bus.op[1] ? in_mag_a : in_mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc <= step_nxt;
                    sh  <= {sh[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                end
                SIGN: begin
                    if (!op_div) begin
                        {hi_r, lo_r} <= prod_fix;
                    end else if (mag_b == '0) begin
                        // Divide by zero returns the raw dividend and an all-ones quotient.
                        lo_r <= '1;
                        hi_r <= neg_a ? -mag_a : mag_a;
                    end else begin
                        lo_r <= quo_fix;
                        hi_r <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi = hi_r;
    assign bus.lo = lo_r;
endmodule
